// File: rtl/tdm_demux_16_if.sv
// Signal bundle between a 16-slot TDM receive stream source and the demultiplexer.
// The master drives the serial slot stream; the slave presents the recovered frame.
interface tdm_demux_16_if;
  logic        enable;
  logic        data_valid;
  logic        data;
  logic        frame_sync;
  logic [15:0] channel_data;
  logic        frame_valid;
  logic [3:0]  slot;
  logic        locked;
  logic        sync_error;

  modport master (
    output enable, data_valid, data, frame_sync,
    input  channel_data, frame_valid, slot, locked, sync_error
  );

  modport slave (
    input  enable, data_valid, data, frame_sync,
    output channel_data, frame_valid, slot, locked, sync_error
  );
endinterface

// File: rtl/tdm_demux_16.sv
// 16-slot TDM receive demultiplexer: hunts for slot-0 sync, tracks slot position,
// collects one frame in a shadow register and publishes it with a one-cycle pulse.
module tdm_demux_16 #(
  parameter int MISS_LIMIT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux_16_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [3:0] MISS_LIMIT_W = MISS_LIMIT[3:0];

  state_t      state_reg, state_next;
  logic [3:0]  slot_reg, slot_next;
  logic [3:0]  miss_reg, miss_next;
  logic [14:0] shadow_reg, shadow_next;
  logic [15:0] channel_data_reg, channel_data_next;
  logic        frame_valid_reg, frame_valid_next;
  logic        sync_error_reg, sync_error_next;

  logic        accept;
  logic [3:0]  miss_inc;
  logic        shadow_wr;
  logic [3:0]  shadow_idx;

  assign accept   = bus.enable & bus.data_valid;
  assign miss_inc = miss_reg + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= HUNT;
      slot_reg         <= 4'd0;
      miss_reg         <= 4'd0;
      shadow_reg       <= 15'd0;
      channel_data_reg <= 16'h0000;
      frame_valid_reg  <= 1'b0;
      sync_error_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      slot_reg         <= slot_next;
      miss_reg         <= miss_next;
      shadow_reg       <= shadow_next;
      channel_data_reg <= channel_data_next;
      frame_valid_reg  <= frame_valid_next;
      sync_error_reg   <= sync_error_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    slot_next         = slot_reg;
    miss_next         = miss_reg;
    channel_data_next = channel_data_reg;
    frame_valid_next  = 1'b0;
    sync_error_next   = 1'b0;
    shadow_wr         = 1'b0;
    shadow_idx        = 4'd0;

    if (accept) begin
      unique case (state_reg)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow_wr  = 1'b1;
            slot_next  = 4'd1;
            miss_next  = 4'd0;
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            // Sync at slot 0 is normal; anywhere else realigns and drops the partial frame.
            sync_error_next = (slot_reg != 4'd0);
            shadow_wr       = 1'b1;
            slot_next       = 4'd1;
            miss_next       = 4'd0;
          end else if (slot_reg == 4'd0) begin
            sync_error_next = 1'b1;
            miss_next       = miss_inc;
            if (miss_inc == MISS_LIMIT_W) begin
              state_next = HUNT;
              slot_next  = 4'd0;
            end else begin
              shadow_wr = 1'b1;
              slot_next = 4'd1;
            end
          end else if (slot_reg == 4'd15) begin
            channel_data_next = {bus.data, shadow_reg};
            frame_valid_next  = 1'b1;
            slot_next         = 4'd0;
          end else begin
            shadow_wr  = 1'b1;
            shadow_idx = slot_reg;
            slot_next  = slot_reg + 4'd1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Per-bit shadow write decode; slot 15 bypasses the shadow straight into the output word.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_shadow
      assign shadow_next[gi] = (shadow_wr && shadow_idx == 4'(gi)) ? bus.data : shadow_reg[gi];
    end
  endgenerate

  assign bus.channel_data = channel_data_reg;
  assign bus.frame_valid  = frame_valid_reg;
  assign bus.slot         = slot_reg;
  assign bus.locked       = (state_reg == LOCKED);
  assign bus.sync_error   = sync_error_reg;

endmodule

// File: tb/tb_tdm_demux_16.sv
// Directed and randomized checks of tdm_demux_16 against a slot-level reference model.
module tb_tdm_demux_16;
  localparam int MISS_LIMIT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_16_if bus ();

  tdm_demux_16 #(.MISS_LIMIT(MISS_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int fv_seen = 0;
  int se_seen = 0;

  // Reference model state: lock flag, next slot, frame under construction, published word.
  bit        m_locked;
  int        m_slot;
  int        m_miss;
  bit [15:0] m_frame;
  bit [15:0] m_out;
  bit        m_fv;
  bit        m_se;

  task automatic model_reset();
    m_locked = 0; m_slot = 0; m_miss = 0;
    m_frame = '0; m_out = '0; m_fv = 0; m_se = 0;
  endtask

  task automatic model(input bit en, input bit dv, input bit d, input bit fs);
    m_fv = 0;
    m_se = 0;
    if (!(en && dv)) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1; m_frame[0] = d; m_slot = 1; m_miss = 0;
      end
      return;
    end
    if (fs) begin
      if (m_slot != 0) m_se = 1;
      m_miss = 0; m_frame[0] = d; m_slot = 1;
    end else if (m_slot == 0) begin
      m_se = 1;
      m_miss++;
      if (m_miss == MISS_LIMIT) begin
        m_locked = 0; m_slot = 0;
      end else begin
        m_frame[0] = d; m_slot = 1;
      end
    end else begin
      m_frame[m_slot] = d;
      if (m_slot == 15) begin
        m_out = m_frame; m_fv = 1; m_slot = 0;
      end else begin
        m_slot++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("channel_data", bus.channel_data, m_out);
    chk("frame_valid", 16'(bus.frame_valid), 16'(m_fv));
    chk("slot", 16'(bus.slot), 16'(m_slot));
    chk("locked", 16'(bus.locked), 16'(m_locked));
    chk("sync_error", 16'(bus.sync_error), 16'(m_se));
  endtask

  task automatic step(input bit en, input bit dv, input bit d, input bit fs);
    @(negedge clk);
    bus.enable = en; bus.data_valid = dv; bus.data = d; bus.frame_sync = fs;
    @(posedge clk);
    model(en, dv, d, fs);
    #1;
    check_model();
    if (bus.frame_valid === 1'b1) fv_seen++;
    if (bus.sync_error === 1'b1) se_seen++;
    $display("[TB] en=%0b dv=%0b d=%0b fs=%0b -> slot=%0d locked=%0b fv=%0b se=%0b data=%h",
             en, dv, d, fs, bus.slot, bus.locked, bus.frame_valid, bus.sync_error, bus.channel_data);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, bus.channel_data, 16'h0000);
    chk({tag, "_fv"}, 16'(bus.frame_valid), 16'h0000);
    chk({tag, "_slot"}, 16'(bus.slot), 16'h0000);
    chk({tag, "_locked"}, 16'(bus.locked), 16'h0000);
    chk({tag, "_se"}, 16'(bus.sync_error), 16'h0000);
  endtask

  task automatic send_frame(input bit [15:0] v, input bit sync0, input bit gaps);
    for (int s = 0; s < 16; s++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        int n = $urandom_range(1, 3);
        for (int g = 0; g < n; g++) step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
      end
      step(1'b1, 1'b1, v[s], (s == 0) && sync0);
    end
  endtask

  initial begin
    int fv0, se0;
    bit [15:0] held;
    bit [15:0] v;
    bus.enable = 0; bus.data_valid = 0; bus.data = 0; bus.frame_sync = 0;
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Lock and capture
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'($urandom), 1'b0);
    chk("hunt_locked", 16'(bus.locked), 16'h0000);
    v = 16'hA5C3;
    se0 = se_seen;
    step(1'b1, 1'b1, v[0], 1'b1);
    chk("lock_after_slot0", 16'(bus.locked), 16'h0001);
    for (int s = 1; s < 16; s++) step(1'b1, 1'b1, v[s], 1'b0);
    chk("capture_data", bus.channel_data, 16'hA5C3);
    chk("capture_fv", 16'(bus.frame_valid), 16'h0001);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("capture_fv_one_cycle", 16'(bus.frame_valid), 16'h0000);
    chk("capture_no_se", 16'(se_seen - se0), 16'h0000);

    // Valid gaps
    fv0 = fv_seen;
    send_frame(16'h1234, 1'b1, 1'b1);
    chk("gaps_data", bus.channel_data, 16'h1234);
    chk("gaps_fv_count", 16'(fv_seen - fv0), 16'h0001);

    // Early sync at slot 7, then a full frame
    fv0 = fv_seen; se0 = se_seen;
    for (int s = 0; s < 7; s++) step(1'b1, 1'b1, 1'b0, s == 0);
    send_frame(16'hFFFF, 1'b1, 1'b0);
    chk("early_se_count", 16'(se_seen - se0), 16'h0001);
    chk("early_fv_count", 16'(fv_seen - fv0), 16'h0001);
    chk("early_data", bus.channel_data, 16'hFFFF);

    // Loss of lock after two missing syncs
    se0 = se_seen;
    send_frame(16'h0F0F, 1'b0, 1'b0);
    chk("miss1_locked", 16'(bus.locked), 16'h0001);
    v = 16'hF0F0;
    step(1'b1, 1'b1, v[0], 1'b0);
    chk("miss2_unlocked", 16'(bus.locked), 16'h0000);
    chk("miss_se_count", 16'(se_seen - se0), 16'h0002);
    for (int s = 1; s < 16; s++) step(1'b1, 1'b1, v[s], 1'b0);
    send_frame(16'h5A0F, 1'b1, 1'b0);
    chk("relock_data", bus.channel_data, 16'h5A0F);
    chk("relock_locked", 16'(bus.locked), 16'h0001);

    // Reset mid-frame at slot 9
    fv0 = fv_seen;
    v = 16'hBEEF;
    for (int s = 0; s < 9; s++) step(1'b1, 1'b1, v[s], s == 0);
    chk("pre_reset_slot", 16'(bus.slot), 16'h0009);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 9; s < 16; s++) step(1'b1, 1'b1, v[s], 1'b0);
    chk("reset_no_fv", 16'(fv_seen - fv0), 16'h0000);
    chk("reset_hunt", 16'(bus.locked), 16'h0000);

    // Enable hold at slot 4
    v = 16'h3C96;
    for (int s = 0; s < 4; s++) step(1'b1, 1'b1, v[s], s == 0);
    held = m_out;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'(i % 2 == 0), 1'($urandom), 1'($urandom));
      chk("hold_slot", 16'(bus.slot), 16'h0004);
      chk("hold_data", bus.channel_data, held);
    end
    for (int s = 4; s < 16; s++) step(1'b1, 1'b1, v[s], 1'b0);
    chk("hold_resume_data", bus.channel_data, 16'h3C96);

    // Randomized traffic with gaps, enable drops, missing and early syncs
    for (int f = 0; f < 40; f++) begin
      v = 16'($urandom);
      for (int s = 0; s < 16; s++) begin
        if ($urandom % 5 == 0) begin
          int n = $urandom_range(1, 3);
          for (int g = 0; g < n; g++)
            step(1'($urandom % 2), 1'($urandom % 2 && $urandom % 2), 1'($urandom), 1'($urandom));
        end
        step(1'b1, 1'b1, v[s], (s == 0) ? ($urandom % 8 != 0) : ($urandom % 40 == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
